// File: rtl/cpu_bus_unit.sv
// rtl/cpu_bus_unit.sv - memory/I-O bus sequencer with configurable latency, ready handshake and timeout
//
// Decodes OUT/WR/IN/RD/LDH/RBS from the current instruction word, forms
// pointer-plus-offset memory addresses, owns the register-bank select and
// stalls the PC (ce=0) while a read or input waits for its data.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pdata           current instruction (held stable while ce=0)
//   a, b            register A (write data) and register B (pointer)
//   min, din        memory / I/O read data
//   mrdy, iordy     memory / I/O data ready
//   ce              PC count enable / instruction retire
//   maddr, msel     memory address and bank select
//   mout, mrd, mwr  memory write data, read strobe, write strobe
//   ioaddr, dout    I/O port number and write data
//   iord, iowr      I/O input / output strobes
//   wb, wdata       register write-back strobe and data
//   bs              register bank select
//   hv, hd          previous retired instruction was LDH, and its byte
//   err             one-cycle timeout pulse
module cpu_bus_unit #(
    parameter int  AW      = 14,
    parameter int  MSW     = 6,
    parameter int  NBANKS  = 4,
    parameter int  RD_LAT  = 1,
    parameter int  IN_LAT  = 1,
    parameter int  TIMEOUT = 15,
    localparam int BSW     = $clog2(NBANKS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     pdata,
    input  logic [15:0]     a,
    input  logic [15:0]     b,
    input  logic [15:0]     min,
    input  logic [15:0]     din,
    input  logic            mrdy,
    input  logic            iordy,
    output logic            ce,
    output logic [AW-1:0]   maddr,
    output logic [MSW-1:0]  msel,
    output logic [15:0]     mout,
    output logic            mrd,
    output logic            mwr,
    output logic [7:0]      ioaddr,
    output logic [15:0]     dout,
    output logic            iord,
    output logic            iowr,
    output logic            wb,
    output logic [15:0]     wdata,
    output logic [BSW-1:0]  bs,
    output logic            hv,
    output logic [7:0]      hd,
    output logic            err
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [7:0]  tcnt, tcnt_nx;
    logic        pend_rd, pend_rd_nx;   // 1: pending RD, 0: pending IN

    logic [3:0]  op, mod;
    logic        is_out, is_wr, is_in, is_rd, is_rbs, is_ldh;
    logic        rdy;
    logic [11:0] ofs;
    logic [BSW-1:0] sel, bs_inc, bs_ld;

    assign op     = pdata[15:12];
    assign mod    = pdata[11:8];
    assign is_out = (op == 4'd8);
    assign is_wr  = (op == 4'd9);
    assign is_in  = (op == 4'd10);
    assign is_rd  = (op == 4'd11);
    assign is_rbs = (op == 4'd15) && (mod == 4'd11);
    assign is_ldh = (op == 4'd15) && (mod == 4'd12);

    // An LDH prefix supplies the high byte of the offset for the next access.
    assign ofs    = {(hv ? hd : 8'h00), mod};
    assign maddr  = b[AW-1:0] + AW'(ofs);
    assign msel   = b[15:16-MSW];
    assign mout   = a;
    assign dout   = a;
    assign ioaddr = pdata[11:4];

    assign rdy    = pend_rd ? mrdy : iordy;

    assign sel    = pdata[BSW-1:0];
    assign bs_inc = (bs == BSW'(NBANKS - 1)) ? '0 : bs + BSW'(1);
    // sel < 2^BSW < 2*NBANKS, so one conditional subtract is a full modulo.
    assign bs_ld  = (int'(sel) >= NBANKS) ? sel - BSW'(NBANKS) : sel;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        tcnt_nx    = tcnt;
        pend_rd_nx = pend_rd;
        ce         = 1'b1;
        mrd        = 1'b0;
        mwr        = 1'b0;
        iord       = 1'b0;
        iowr       = 1'b0;
        wb         = 1'b0;
        wdata      = 16'h0000;
        err        = 1'b0;
        case (state)
            IDLE: begin
                // Outputs stay idle-valued while reset is held, whatever pdata says.
                if (!rst) begin
                    iowr = is_out;
                    mwr  = is_wr;
                    if (is_rd || is_in) begin
                        ce         = 1'b0;
                        mrd        = is_rd;
                        iord       = is_in;
                        pend_rd_nx = is_rd;
                        cnt_nx     = is_rd ? 4'(RD_LAT - 1) : 4'(IN_LAT - 1);
                        tcnt_nx    = 8'h00;
                        state_nx   = WAIT;
                    end
                end
            end
            WAIT: begin
                ce = 1'b0;
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else if (rdy) begin
                    wb       = 1'b1;
                    wdata    = pend_rd ? min : din;
                    ce       = 1'b1;
                    state_nx = IDLE;
                end else if ((TIMEOUT != 0) && (tcnt == 8'(TIMEOUT))) begin
                    wb       = 1'b1;
                    wdata    = 16'hFFFF;
                    err      = 1'b1;
                    ce       = 1'b1;
                    state_nx = IDLE;
                end else begin
                    tcnt_nx = tcnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tcnt    <= '0;
            pend_rd <= 1'b0;
            bs      <= '0;
            hv      <= 1'b0;
            hd      <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            tcnt    <= tcnt_nx;
            pend_rd <= pend_rd_nx;
            if (state == IDLE && is_rbs)
                bs <= pdata[4] ? bs_inc : bs_ld;
            // Held across a stall, so an LDH prefix reaches the following RD.
            if (ce) begin
                hv <= is_ldh;
                hd <= pdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_unit.sv
// tb/tb_cpu_bus_unit.sv - self-checking bench for cpu_bus_unit
module tb_cpu_bus_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pdata, a, b, min, din;
    logic        mrdy, iordy;
    logic        ce, mrd, mwr, iord, iowr, wb, hv, err;
    logic [13:0] maddr;
    logic [5:0]  msel;
    logic [15:0] mout, dout, wdata;
    logic [7:0]  ioaddr, hd;
    logic [1:0]  bs;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] wdata;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [15:0] pdata, a, b;
        logic        e_ce, e_mwr, e_iowr;
        logic [13:0] e_maddr;
        logic [5:0]  e_msel;
        logic [1:0]  e_bs;
        logic        e_hv;
    } vec_t;
    vec_t vt[10];

    cpu_bus_unit #(
        .AW(14), .MSW(6), .NBANKS(4), .RD_LAT(3), .IN_LAT(1), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .pdata(pdata), .a(a), .b(b), .min(min), .din(din),
        .mrdy(mrdy), .iordy(iordy), .ce(ce), .maddr(maddr), .msel(msel),
        .mout(mout), .mrd(mrd), .mwr(mwr), .ioaddr(ioaddr), .dout(dout),
        .iord(iord), .iowr(iowr), .wb(wb), .wdata(wdata), .bs(bs), .hv(hv),
        .hd(hd), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: sample mid-cycle, compare control outputs, pop the
    // scoreboard on every write-back, then advance to the next negedge.
    task automatic cyc(input string nm, input logic e_ce, input logic e_mrd,
                       input logic e_iord, input logic e_wb, input logic e_err);
        exp_t e;
        #1;
        chk({nm, ".ce"},   ce,   e_ce);
        chk({nm, ".mrd"},  mrd,  e_mrd);
        chk({nm, ".iord"}, iord, e_iord);
        chk({nm, ".wb"},   wb,   e_wb);
        chk({nm, ".err"},  err,  e_err);
        if (wb === 1'b1) begin
            if (sbq.size() == 0) begin
                chk({nm, ".sb_depth"}, sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                chk({nm, ".wdata"},  wdata, e.wdata);
                chk({nm, ".wb_err"}, err,   e.err);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vt[0] = '{16'h8A35, 16'h1234, 16'h0040, 1'b1, 1'b0, 1'b1, 14'h004A, 6'h00, 2'd0, 1'b0};
        vt[1] = '{16'h9507, 16'hBEEF, 16'hC123, 1'b1, 1'b1, 1'b0, 14'h0128, 6'h30, 2'd0, 1'b0};
        vt[2] = '{16'hFB03, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h000B, 6'h00, 2'd3, 1'b0};
        vt[3] = '{16'hFB10, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h000B, 6'h00, 2'd0, 1'b0};
        vt[4] = '{16'hFB12, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h000B, 6'h00, 2'd1, 1'b0};
        vt[5] = '{16'hFB06, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h000B, 6'h00, 2'd2, 1'b0};
        vt[6] = '{16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h0002, 6'h00, 2'd2, 1'b0};
        vt[7] = '{16'hFCAB, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h000C, 6'h00, 2'd2, 1'b1};
        vt[8] = '{16'h9300, 16'h7777, 16'h3FFF, 1'b1, 1'b1, 1'b0, 14'h0AB2, 6'h0F, 2'd2, 1'b0};
        vt[9] = '{16'h8000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 14'h3FFF, 6'h3F, 2'd2, 1'b0};

        // Reset state, with an RD word present to show the outputs stay idle.
        rst = 1'b1; pdata = 16'hB312; a = 16'h0; b = 16'h0100;
        min = 16'h0; din = 16'h0; mrdy = 1'b0; iordy = 1'b0;
        @(negedge clk);
        #1;
        chk("rst.ce", ce, 1'b1);
        chk("rst.mrd", mrd, 1'b0);
        chk("rst.wb", wb, 1'b0);
        chk("rst.err", err, 1'b0);
        chk("rst.bs", bs, 2'd0);
        chk("rst.hv", hv, 1'b0);
        chk("rst.hd", hd, 8'h00);
        pdata = 16'h0000;
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle instructions.
        for (int i = 0; i < 10; i++) begin
            pdata = vt[i].pdata; a = vt[i].a; b = vt[i].b;
            #1;
            chk($sformatf("vec%0d.mwr", i),    mwr,    vt[i].e_mwr);
            chk($sformatf("vec%0d.iowr", i),   iowr,   vt[i].e_iowr);
            chk($sformatf("vec%0d.maddr", i),  maddr,  vt[i].e_maddr);
            chk($sformatf("vec%0d.msel", i),   msel,   vt[i].e_msel);
            chk($sformatf("vec%0d.mout", i),   mout,   vt[i].a);
            chk($sformatf("vec%0d.dout", i),   dout,   vt[i].a);
            chk($sformatf("vec%0d.ioaddr", i), ioaddr, vt[i].pdata[11:4]);
            cyc($sformatf("vec%0d", i), vt[i].e_ce, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d.bs", i), bs, vt[i].e_bs);
            chk($sformatf("vec%0d.hv", i), hv, vt[i].e_hv);
        end

        // IN with IN_LAT=1 and ready already high: legacy 2-cycle timing.
        pdata = 16'hA051; din = 16'h5A5A; iordy = 1'b1;
        sbq.push_back('{16'h5A5A, 1'b0});
        #1; chk("in.ioaddr", ioaddr, 8'h05);
        cyc("in.c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("in.c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // LDH prefix then RD (RD_LAT=3): offset 0x123, hv survives the stall.
        pdata = 16'hFC12; b = 16'h0010; iordy = 1'b0;
        cyc("ldh", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ldh.hd", hd, 8'h12);
        pdata = 16'hB345; min = 16'hCAFE; mrdy = 1'b1;
        sbq.push_back('{16'hCAFE, 1'b0});
        #1; chk("pre.maddr0", maddr, 14'h0133);
        cyc("pre.c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            #1;
            chk($sformatf("pre.c%0d.hv", i), hv, 1'b1);
            chk($sformatf("pre.c%0d.maddr", i), maddr, 14'h0133);
            cyc($sformatf("pre.c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc("pre.c3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // RD_LAT=3, early ready ignored, then ready low for 2 extra cycles.
        pdata = 16'hB0F0; b = 16'h0200; min = 16'h1357; mrdy = 1'b1;
        sbq.push_back('{16'h1357, 1'b0});
        #1; chk("stall.hv_cleared", hv, 1'b0);
        cyc("stall.c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("stall.c1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("stall.c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mrdy = 1'b0;
        cyc("stall.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("stall.c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mrdy = 1'b1;
        cyc("stall.c5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // IN timeout: TIMEOUT=4, iordy never rises.
        pdata = 16'hA051; iordy = 1'b0; mrdy = 1'b0;
        sbq.push_back('{16'hFFFF, 1'b1});
        cyc("to.c0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++)
            cyc($sformatf("to.c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("to.c5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        pdata = 16'h0000;
        cyc("to.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a WAIT, then a normal RD.
        pdata = 16'hFB01;
        cyc("rbs1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rbs1.bs", bs, 2'd1);
        pdata = 16'hB000; b = 16'h0000; min = 16'h2468; mrdy = 1'b0;
        sbq.push_back('{16'h2468, 1'b0});
        cyc("mid.c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("mid.c1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2; rst = 1'b1;
        #1;
        chk("mid.rst.ce", ce, 1'b1);
        chk("mid.rst.mrd", mrd, 1'b0);
        chk("mid.rst.wb", wb, 1'b0);
        chk("mid.rst.err", err, 1'b0);
        chk("mid.rst.bs", bs, 2'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0; mrdy = 1'b1;
        sbq.push_back('{16'h2468, 1'b0});
        cyc("post.c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("post.c1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("post.c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("post.c3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        chk("sb.empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
